// File: rtl/counter_updown_mod.sv
// Modulo up/down counter: variable step, load/init, wrap or saturate, wrap pulse, sticky flags; optional COUNTER_PRESCALER_EN enable prescaler.
// Updates show on o_value one cycle after the edge; no backpressure, every qualifying cycle is accepted.
module counter_updown_mod #(
  parameter int BITS      = 8,
  parameter int STEP_BITS = 4,
  parameter int PRESCALE  = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 i_enable,
  input  logic                 i_init,
  input  logic                 i_load,
  input  logic [BITS-1:0]      i_load_value,
  input  logic                 i_inc_dec,
  input  logic [STEP_BITS-1:0] i_step,
  input  logic [BITS-1:0]      i_limit,
  input  logic                 i_saturate,
  input  logic                 i_clear_flags,
  output logic [BITS-1:0]      o_value,
  output logic                 o_at_zero,
  output logic                 o_at_limit,
  output logic                 o_wrap,
  output logic                 o_overflow,
  output logic                 o_underflow
);

  localparam logic [BITS:0] ONE_X = {{BITS{1'b0}}, 1'b1};

  logic [BITS-1:0] value_q, value_d;
  logic            wrap_q, wrap_d;
  logic            ovf_q, ovf_d;
  logic            unf_q, unf_d;
  logic            tick;
  logic [BITS:0]   val_x, lim_x, lim1_x, stp_x, sum_x, tmp_x, dif_x;
  logic            up_evt, dn_evt;

`ifdef COUNTER_PRESCALER_EN
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PLAST = PW'(PRESCALE - 1);

  logic [PW-1:0] presc_q, presc_d;

  always_comb begin
    presc_d = presc_q;
    tick    = 1'b0;
    if (i_init || i_load) begin
      presc_d = '0;
    end else if (i_enable) begin
      if (presc_q == PLAST) begin
        presc_d = '0;
        tick    = 1'b1;
      end else begin
        presc_d = presc_q + PW'(1);
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) presc_q <= '0;
    else       presc_q <= presc_d;
  end
`else
  assign tick = i_enable & (PRESCALE > 0);
`endif

  // All arithmetic is one bit wider than the count so limit+1 and value+step never alias.
  always_comb begin
    val_x  = {1'b0, value_q};
    lim_x  = {1'b0, i_limit};
    lim1_x = lim_x + ONE_X;
    stp_x  = '0;
    stp_x[STEP_BITS-1:0] = i_step;
    sum_x  = val_x + stp_x;
    tmp_x  = '0;
    dif_x  = '0;
    up_evt = 1'b0;
    dn_evt = 1'b0;
    value_d = value_q;

    if (i_init) begin
      value_d = '0;
    end else if (i_load) begin
      value_d = (i_load_value > i_limit) ? i_limit : i_load_value;
    end else if (tick && (i_step != '0)) begin
      if (i_inc_dec) begin
        if (sum_x > lim_x) begin
          up_evt = 1'b1;
          tmp_x  = sum_x - lim1_x;
          if (i_saturate || (tmp_x > lim_x)) value_d = i_limit;
          else                               value_d = tmp_x[BITS-1:0];
        end else begin
          value_d = sum_x[BITS-1:0];
        end
      end else begin
        if (stp_x > val_x) begin
          dn_evt = 1'b1;
          tmp_x  = val_x + lim1_x;
          dif_x  = tmp_x - stp_x;
          if (i_saturate || (tmp_x < stp_x) || (dif_x > lim_x)) value_d = '0;
          else                                                 value_d = dif_x[BITS-1:0];
        end else begin
          dif_x   = val_x - stp_x;
          value_d = dif_x[BITS-1:0];
        end
      end
    end

    wrap_d = up_evt | dn_evt;
    ovf_d  = (ovf_q & ~i_clear_flags) | up_evt;
    unf_d  = (unf_q & ~i_clear_flags) | dn_evt;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      value_q <= '0;
      wrap_q  <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      value_q <= value_d;
      wrap_q  <= wrap_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign o_value     = value_q;
  assign o_at_zero   = (value_q == '0);
  assign o_at_limit  = (value_q == i_limit);
  assign o_wrap      = wrap_q;
  assign o_overflow  = ovf_q;
  assign o_underflow = unf_q;

endmodule

// File: tb/tb_counter_updown_mod.sv
// Randomised and directed bench for counter_updown_mod against an integer reference model.
module tb_counter_updown_mod;
  localparam int BITS = 8, STEP_BITS = 4, PRESCALE = 4;
`ifdef COUNTER_PRESCALER_EN
  localparam int PS = PRESCALE;
`else
  localparam int PS = 1;
`endif

  logic clock = 1'b0;
  logic reset;
  logic i_enable, i_init, i_load, i_inc_dec, i_saturate, i_clear_flags;
  logic [BITS-1:0] i_load_value, i_limit;
  logic [STEP_BITS-1:0] i_step;
  logic [BITS-1:0] o_value;
  logic o_at_zero, o_at_limit, o_wrap, o_overflow, o_underflow;

  int n_tests = 0, n_fail = 0;
  int m_val, m_presc;
  bit m_wrap, m_ovf, m_unf;

  counter_updown_mod #(.BITS(BITS), .STEP_BITS(STEP_BITS), .PRESCALE(PRESCALE)) dut (
    .clock(clock), .reset(reset), .i_enable(i_enable), .i_init(i_init), .i_load(i_load),
    .i_load_value(i_load_value), .i_inc_dec(i_inc_dec), .i_step(i_step), .i_limit(i_limit),
    .i_saturate(i_saturate), .i_clear_flags(i_clear_flags), .o_value(o_value),
    .o_at_zero(o_at_zero), .o_at_limit(o_at_limit), .o_wrap(o_wrap),
    .o_overflow(o_overflow), .o_underflow(o_underflow));

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // Reference: next state from the counting rules in plain integer arithmetic.
  task automatic tick_clk();
    int v, lim, s, nv, np;
    bit upd, eu, ed, clr;
    v = m_val; lim = int'(i_limit); s = int'(i_step); clr = i_clear_flags;
    nv = v; np = m_presc; upd = 0; eu = 0; ed = 0;
    if (i_init) begin
      nv = 0; np = 0;
    end else if (i_load) begin
      nv = (int'(i_load_value) > lim) ? lim : int'(i_load_value); np = 0;
    end else begin
      if (i_enable) begin
        upd = (m_presc == PS - 1);
        np  = (m_presc + 1) % PS;
      end
      if (upd && s != 0) begin
        if (i_inc_dec) begin
          if (v + s > lim) begin
            eu = 1;
            nv = i_saturate ? lim : v + s - (lim + 1);
            if (nv > lim) nv = lim;
          end else nv = v + s;
        end else begin
          if (s > v) begin
            ed = 1;
            nv = i_saturate ? 0 : v + lim + 1 - s;
            if (nv < 0 || nv > lim) nv = 0;
          end else nv = v - s;
        end
      end
    end
    @(posedge clock);
    m_val = nv; m_presc = np; m_wrap = eu | ed;
    m_ovf = (m_ovf && !clr) || eu;
    m_unf = (m_unf && !clr) || ed;
    #1;
  endtask

  task automatic tick_update();
    repeat (PS) tick_clk();
  endtask

  task automatic idle_inputs();
    i_enable = 0; i_init = 0; i_load = 0; i_load_value = '0; i_inc_dec = 1;
    i_step = '0; i_limit = 8'd255; i_saturate = 0; i_clear_flags = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1;
    @(posedge clock); #1;
    m_val = 0; m_presc = 0; m_wrap = 0; m_ovf = 0; m_unf = 0;
    n_tests++; if (o_value !== 8'd0) begin n_fail++; $display("FAIL reset_value: got %0d expected 0", o_value); end
    n_tests++; if ({o_wrap, o_overflow, o_underflow} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got %b expected 000", {o_wrap, o_overflow, o_underflow}); end
    n_tests++; if (o_at_zero !== 1'b1) begin n_fail++; $display("FAIL reset_at_zero: got %b expected 1", o_at_zero); end
    reset = 0;
  endtask

  task automatic test_mod10();
    int wraps = 0;
    i_limit = 8'd9; i_saturate = 0; i_step = 4'd1; i_inc_dec = 1; i_enable = 1;
    for (int k = 1; k <= 10; k++) begin
      tick_update();
      if (o_wrap) wraps++;
      n_tests++; if (o_value !== 8'(k % 10)) begin n_fail++; $display("FAIL mod10_value[%0d]: got %0d expected %0d", k, o_value, k % 10); end
      n_tests++; if (o_wrap !== (k == 10)) begin n_fail++; $display("FAIL mod10_wrap[%0d]: got %b expected %b", k, o_wrap, k == 10); end
      n_tests++; if (o_at_limit !== (k == 9)) begin n_fail++; $display("FAIL mod10_at_limit[%0d]: got %b expected %b", k, o_at_limit, k == 9); end
    end
    n_tests++; if (wraps != 1) begin n_fail++; $display("FAIL mod10_wrap_count: got %0d expected 1", wraps); end
    n_tests++; if (o_overflow !== 1'b1) begin n_fail++; $display("FAIL mod10_overflow: got %b expected 1", o_overflow); end
  endtask

  task automatic test_saturate();
    int exp;
    i_limit = 8'd200; i_saturate = 1; i_enable = 0; i_load = 1; i_load_value = 8'd198;
    tick_clk();
    i_load = 0; i_enable = 1; i_inc_dec = 1; i_step = 4'd5;
    tick_update();
    n_tests++; if (o_value !== 8'd200) begin n_fail++; $display("FAIL sat_up_value: got %0d expected 200", o_value); end
    n_tests++; if ({o_wrap, o_overflow} !== 2'b11) begin n_fail++; $display("FAIL sat_up_flags: got %b expected 11", {o_wrap, o_overflow}); end
    i_inc_dec = 0;
    for (int k = 1; k <= 41; k++) begin
      tick_update();
      exp = (200 - 5 * k < 0) ? 0 : 200 - 5 * k;
      n_tests++; if (o_value !== 8'(exp)) begin n_fail++; $display("FAIL sat_down_value[%0d]: got %0d expected %0d", k, o_value, exp); end
      n_tests++; if (o_wrap !== (k == 41)) begin n_fail++; $display("FAIL sat_down_wrap[%0d]: got %b expected %b", k, o_wrap, k == 41); end
    end
    n_tests++; if ({o_overflow, o_underflow} !== 2'b11) begin n_fail++; $display("FAIL sat_sticky: got %b expected 11", {o_overflow, o_underflow}); end
  endtask

  task automatic test_down_wrap_clear();
    i_enable = 0; i_clear_flags = 1;
    tick_clk();
    n_tests++; if ({o_overflow, o_underflow} !== 2'b00) begin n_fail++; $display("FAIL clear_flags: got %b expected 00", {o_overflow, o_underflow}); end
    i_clear_flags = 0; i_limit = 8'd15; i_saturate = 0; i_load = 1; i_load_value = 8'd2;
    tick_clk();
    i_load = 0; i_enable = 1; i_inc_dec = 0; i_step = 4'd5;
    tick_update();
    n_tests++; if (o_value !== 8'd13) begin n_fail++; $display("FAIL down_wrap_value: got %0d expected 13", o_value); end
    n_tests++; if ({o_wrap, o_underflow} !== 2'b11) begin n_fail++; $display("FAIL down_wrap_flags: got %b expected 11", {o_wrap, o_underflow}); end
    i_enable = 0; i_load = 1; i_load_value = 8'd3;
    tick_clk();
    i_load = 0; i_enable = 1; i_clear_flags = 1;
    tick_update();
    n_tests++; if (o_value !== 8'd14) begin n_fail++; $display("FAIL clear_event_value: got %0d expected 14", o_value); end
    n_tests++; if (o_underflow !== 1'b1) begin n_fail++; $display("FAIL clear_event_wins: got %b expected 1", o_underflow); end
    i_enable = 0;
    tick_clk();
    i_clear_flags = 0;
    n_tests++; if (o_underflow !== 1'b0) begin n_fail++; $display("FAIL clear_alone: got %b expected 0", o_underflow); end
  endtask

  task automatic test_priority();
    i_init = 1; i_load = 1; i_load_value = 8'd77; i_enable = 1; i_inc_dec = 1; i_step = 4'd1;
    tick_clk();
    n_tests++; if (o_value !== 8'd0) begin n_fail++; $display("FAIL prio_init: got %0d expected 0", o_value); end
    i_init = 0; i_enable = 0; i_limit = 8'd100; i_load_value = 8'd250;
    tick_clk();
    i_load = 0;
    n_tests++; if (o_value !== 8'd100) begin n_fail++; $display("FAIL load_clamp: got %0d expected 100", o_value); end
    n_tests++; if (o_at_limit !== 1'b1) begin n_fail++; $display("FAIL load_at_limit: got %b expected 1", o_at_limit); end
  endtask

  task automatic test_step_zero_limit_zero();
    i_enable = 1; i_step = 4'd0; i_inc_dec = 1;
    tick_update();
    n_tests++; if ({o_value, o_wrap} !== {8'd100, 1'b0}) begin n_fail++; $display("FAIL step_zero: got %0d/%b expected 100/0", o_value, o_wrap); end
    i_limit = 8'd0; i_saturate = 0; i_enable = 0; i_load = 1; i_load_value = 8'd5;
    tick_clk();
    i_load = 0; i_enable = 1; i_step = 4'd3;
    tick_update();
    n_tests++; if ({o_value, o_wrap} !== {8'd0, 1'b1}) begin n_fail++; $display("FAIL limit0_up: got %0d/%b expected 0/1", o_value, o_wrap); end
    i_inc_dec = 0; i_step = 4'd1;
    tick_update();
    n_tests++; if ({o_value, o_wrap, o_underflow} !== {8'd0, 2'b11}) begin n_fail++; $display("FAIL limit0_down: got %0d/%b/%b expected 0/1/1", o_value, o_wrap, o_underflow); end
  endtask

  task automatic test_async_reset();
    i_limit = 8'd100; i_saturate = 1; i_enable = 0; i_load = 1; i_load_value = 8'd98;
    tick_clk();
    i_load = 0; i_enable = 1; i_inc_dec = 1; i_step = 4'd5;
    tick_update();
    i_enable = 0; i_load = 1; i_load_value = 8'd37;
    tick_clk();
    i_load = 0;
    n_tests++; if ({o_value, o_overflow} !== {8'd37, 1'b1}) begin n_fail++; $display("FAIL pre_reset: got %0d/%b expected 37/1", o_value, o_overflow); end
    i_enable = 1; i_step = 4'd1;
    tick_clk();
    #3 reset = 1;
    #1;
    n_tests++; if ({o_value, o_wrap, o_overflow, o_underflow} !== 11'd0) begin n_fail++; $display("FAIL async_reset: got %0d/%b%b%b expected 0/000", o_value, o_wrap, o_overflow, o_underflow); end
    m_val = 0; m_presc = 0; m_wrap = 0; m_ovf = 0; m_unf = 0;
    @(posedge clock); #1;
    reset = 0;
    tick_update();
    n_tests++; if (o_value !== 8'd1) begin n_fail++; $display("FAIL resume_after_reset: got %0d expected 1", o_value); end
  endtask

  task automatic test_prescale();
    i_init = 1;
    tick_clk();
    i_init = 0; i_limit = 8'd255; i_saturate = 0; i_step = 4'd1; i_inc_dec = 1; i_enable = 1;
    repeat (12) tick_clk();
    n_tests++; if (o_value !== 8'(12 / PS)) begin n_fail++; $display("FAIL prescale_count: got %0d expected %0d", o_value, 12 / PS); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      i_init        = ($urandom_range(0, 31) == 0);
      i_load        = ($urandom_range(0, 15) == 0);
      i_load_value  = 8'($urandom_range(0, 255));
      i_enable      = ($urandom_range(0, 3) != 0);
      i_inc_dec     = 1'($urandom_range(0, 1));
      i_step        = 4'($urandom_range(0, 15));
      i_clear_flags = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 19) == 0) i_limit = ($urandom_range(0, 4) == 0) ? 8'd0 : 8'($urandom_range(0, 255));
      if ($urandom_range(0, 9) == 0) i_saturate = ~i_saturate;
      tick_clk();
      n_tests++; if (o_value !== 8'(m_val)) begin n_fail++; $display("FAIL rnd_value[%0d]: got %0d expected %0d", c, o_value, m_val); end
      n_tests++; if (o_wrap !== m_wrap) begin n_fail++; $display("FAIL rnd_wrap[%0d]: got %b expected %b", c, o_wrap, m_wrap); end
      n_tests++; if (o_overflow !== m_ovf) begin n_fail++; $display("FAIL rnd_overflow[%0d]: got %b expected %b", c, o_overflow, m_ovf); end
      n_tests++; if (o_underflow !== m_unf) begin n_fail++; $display("FAIL rnd_underflow[%0d]: got %b expected %b", c, o_underflow, m_unf); end
      n_tests++; if (o_at_zero !== (m_val == 0)) begin n_fail++; $display("FAIL rnd_at_zero[%0d]: got %b expected %b", c, o_at_zero, m_val == 0); end
      n_tests++; if (o_at_limit !== (m_val == int'(i_limit))) begin n_fail++; $display("FAIL rnd_at_limit[%0d]: got %b expected %b", c, o_at_limit, m_val == int'(i_limit)); end
    end
  endtask

  initial begin
    test_reset();
    test_mod10();
    test_saturate();
    test_down_wrap_clear();
    test_priority();
    test_step_zero_limit_zero();
    test_async_reset();
    test_prescale();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
